// File: rtl/vga_draw_arbiter.sv
// Arbitrates TILE x TILE square draws from NREQ requesters onto one VGA plot path.
// Define VGA_DRAW_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, index 0 first).
// state  | meaning
// IDLE   | waiting for any req; arbitrate and latch winner
// DRAW   | plotting one pixel per cycle, row-major
// FINISH | one-cycle done pulse to the owner
module vga_draw_arbiter #(
    parameter int NREQ = 3,
    parameter int TILE = 4,
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int CW   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*XW-1:0] req_x,
    input  logic [NREQ*YW-1:0] req_y,
    input  logic [NREQ*CW-1:0] req_colour,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic [XW-1:0]      x_out,
    output logic [YW-1:0]      y_out,
    output logic [CW-1:0]      colour_out,
    output logic               plot,
    output logic               busy
);
    localparam int LT   = $clog2(TILE);
    localparam int CNTW = 2 * LT;
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(TILE * TILE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic [XW-1:0]   r_base_x;
    logic [YW-1:0]   r_base_y;
    logic [CW-1:0]   r_colour;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_win;
    logic            w_any;
    logic            w_draw;
    logic [LT-1:0]   w_col;
    logic [LT-1:0]   w_row;
    logic [NREQ-1:0] w_onehot;

    assign w_any = |req;

`ifdef VGA_DRAW_ARBITER_ROUND_ROBIN_EN
    logic [OW-1:0] r_ptr;
    logic [OW-1:0] w_idx;

    // Descending scan so the candidate closest after the pointer is assigned last and wins.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = OW'((int'(r_ptr) + 1 + k) % NREQ);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_ptr <= OW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_any) begin
            r_ptr <= w_win;
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_win = OW'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_DRAW;
            S_DRAW:   if (r_cnt == LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_cnt    <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
            r_colour <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_base_x <= req_x[w_win*XW +: XW];
                        r_base_y <= req_y[w_win*YW +: YW];
                        r_colour <= req_colour[w_win*CW +: CW];
                        r_owner  <= w_win;
                        r_cnt    <= '0;
                    end
                end
                S_DRAW:  r_cnt <= r_cnt + CNTW'(1);
                default: ;
            endcase
        end
    end

    // Outputs decode only registered state, so req never reaches them combinationally.
    assign w_draw     = (r_state == S_DRAW);
    assign w_col      = r_cnt[LT-1:0];
    assign w_row      = r_cnt[CNTW-1:LT];
    assign w_onehot   = NREQ'(1) << r_owner;
    assign grant      = w_draw ? w_onehot : '0;
    assign done       = (r_state == S_FINISH) ? w_onehot : '0;
    assign plot       = w_draw;
    assign busy       = (r_state != S_IDLE);
    assign x_out      = w_draw ? r_base_x + XW'(w_col) : '0;
    assign y_out      = w_draw ? r_base_y + YW'(w_row) : '0;
    assign colour_out = w_draw ? r_colour : '0;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed self-checking bench for vga_draw_arbiter (NREQ=3, TILE=4, XW=8, YW=7, CW=3).
module tb_vga_draw_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [7:0]  tx [3];
    logic [6:0]  ty [3];
    logic [2:0]  tc [3];
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot;
    logic        busy;
    int          total = 0;
    int          bad   = 0;

    assign req_x      = {tx[2], tx[1], tx[0]};
    assign req_y      = {ty[2], ty[1], ty[0]};
    assign req_colour = {tc[2], tc[1], tc[0]};

    always #5 clk = ~clk;

    vga_draw_arbiter #(.NREQ(3), .TILE(4), .XW(8), .YW(7), .CW(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy)
    );

    task automatic do_reset();
        req    = 3'b000;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        req    = 3'b111;
        tx[0] = 8'd33; ty[0] = 7'd44; tc[0] = 3'd6;
        @(negedge clk);
        total++;
        if ({grant, done, plot, busy, x_out, y_out, colour_out} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {grant, done, plot, busy, x_out, y_out, colour_out});
        end
        @(negedge clk);
        total++;
        if ({grant, plot, busy} !== 5'd0) begin
            bad++;
            $display("FAIL reset_held: got %b want 00000", {grant, plot, busy});
        end
        req    = 3'b000;
        resetn = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, grant, plot} !== 5'd0) begin
            bad++;
            $display("FAIL idle_no_req: got %b want 00000", {busy, grant, plot});
        end
    endtask

    task automatic test_single();
        logic [7:0] ex;
        logic [6:0] ey;
        do_reset();
        tx[1] = 8'd10; ty[1] = 7'd20; tc[1] = 3'd5;
        req = 3'b010;
        @(negedge clk);
        total++;
        if ({grant, busy} !== 4'b0101) begin
            bad++;
            $display("FAIL single_grant: got %b want 0101", {grant, busy});
        end
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk);
            ex = 8'(10 + p % 4);
            ey = 7'(20 + p / 4);
            total++;
            if ({plot, x_out, y_out, colour_out} !== {1'b1, ex, ey, 3'd5}) begin
                bad++;
                $display("FAIL single_pixel%0d: got p=%b x=%0d y=%0d c=%0d want p=1 x=%0d y=%0d c=5",
                         p, plot, x_out, y_out, colour_out, ex, ey);
            end
        end
        @(negedge clk);
        total++;
        if ({done, grant, plot} !== 7'b0100000) begin
            bad++;
            $display("FAIL single_done: got %b want 0100000", {done, grant, plot});
        end
        req = 3'b000;
        @(negedge clk);
        total++;
        if ({busy, done, plot} !== 5'd0) begin
            bad++;
            $display("FAIL single_idle: got %b want 00000", {busy, done, plot});
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp;
        int multi;
        do_reset();
        tx[0] = 8'd0;  ty[0] = 7'd0;  tc[0] = 3'd1;
        tx[1] = 8'd20; ty[1] = 7'd30; tc[1] = 3'd2;
        tx[2] = 8'd40; ty[2] = 7'd60; tc[2] = 3'd4;
        req = 3'b111;
        for (int n = 0; n < 3; n++) begin
            exp   = 3'b001 << n;
            multi = 0;
            @(negedge clk);
            total++;
            if (grant !== exp) begin
                bad++;
                $display("FAIL simul_grant%0d: got %b want %b", n, grant, exp);
            end
            for (int p = 0; p < 16; p++) begin
                if (p > 0) @(negedge clk);
                if (!$onehot0(grant) || plot !== 1'b1) multi++;
            end
            total++;
            if (multi !== 0) begin
                bad++;
                $display("FAIL simul_onehot%0d: got %0d bad cycles want 0", n, multi);
            end
            @(negedge clk);
            total++;
            if ({done, grant} !== {exp, 3'b000}) begin
                bad++;
                $display("FAIL simul_done%0d: got %b want %b", n, {done, grant}, {exp, 3'b000});
            end
            req = req & ~exp;
            @(negedge clk);
            total++;
            if ({busy, grant, done} !== 7'd0) begin
                bad++;
                $display("FAIL simul_idle%0d: got %b want 0000000", n, {busy, grant, done});
            end
        end
    endtask

    task automatic test_rr();
        logic [2:0] exp [3];
`ifdef VGA_DRAW_ARBITER_ROUND_ROBIN_EN
        exp = '{3'b001, 3'b010, 3'b001};
`else
        exp = '{3'b001, 3'b001, 3'b001};
`endif
        do_reset();
        req = 3'b011;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if (grant !== exp[n]) begin
                bad++;
                $display("FAIL arb_grant%0d: got %b want %b", n, grant, exp[n]);
            end
            repeat (16) @(negedge clk);
            total++;
            if (done !== exp[n]) begin
                bad++;
                $display("FAIL arb_done%0d: got %b want %b", n, done, exp[n]);
            end
            req = req & ~exp[n];
            @(negedge clk);
            req = 3'b011;
        end
        req = 3'b000;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [7:0] xs [4];
        logic [6:0] ys [4];
        xs = '{8'd254, 8'd255, 8'd0, 8'd1};
        ys = '{7'd126, 7'd127, 7'd0, 7'd1};
        do_reset();
        tx[2] = 8'd254; ty[2] = 7'd126; tc[2] = 3'd3;
        req = 3'b100;
        @(negedge clk);
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk);
            total++;
            if ({plot, grant, x_out, y_out, colour_out} !== {1'b1, 3'b100, xs[p % 4], ys[p / 4], 3'd3}) begin
                bad++;
                $display("FAIL wrap_pixel%0d: got x=%0d y=%0d c=%0d g=%b want x=%0d y=%0d c=3 g=100",
                         p, x_out, y_out, colour_out, grant, xs[p % 4], ys[p / 4]);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 3'b100) begin
            bad++;
            $display("FAIL wrap_done: got %b want 100", done);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dseen;
        logic [7:0] ex;
        logic [6:0] ey;
        do_reset();
        tx[0] = 8'd5; ty[0] = 7'd6; tc[0] = 3'd7;
        req = 3'b001;
        @(negedge clk);
        repeat (6) @(negedge clk);
        total++;
        if ({plot, x_out, y_out} !== {1'b1, 8'd7, 7'd7}) begin
            bad++;
            $display("FAIL rstmid_7th: got p=%b x=%0d y=%0d want p=1 x=7 y=7", plot, x_out, y_out);
        end
        resetn = 1'b1;
        req    = 3'b000;
        @(negedge clk);
        total++;
        if ({plot, grant, busy, done} !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_clear: got %b want 00000000", {plot, grant, busy, done});
        end
        resetn = 1'b0;
        dseen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 3'b000) dseen++;
        end
        total++;
        if (dseen !== 0) begin
            bad++;
            $display("FAIL rstmid_nodone: got %0d done cycles want 0", dseen);
        end
        req = 3'b001;
        @(negedge clk);
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk);
            ex = 8'(5 + p % 4);
            ey = 7'(6 + p / 4);
            total++;
            if ({plot, x_out, y_out, colour_out} !== {1'b1, ex, ey, 3'd7}) begin
                bad++;
                $display("FAIL rstmid_pixel%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=7",
                         p, x_out, y_out, colour_out, ex, ey);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 3'b001) begin
            bad++;
            $display("FAIL rstmid_done: got %b want 001", done);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        int plots;
        int dones;
        int perr;
        do_reset();
        tx[2] = 8'd40; ty[2] = 7'd50; tc[2] = 3'd2;
        req   = 3'b100;
        plots = 0;
        dones = 0;
        perr  = 0;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            if (plot === 1'b1) begin
                if ({x_out, y_out, colour_out} !== {8'(40 + plots % 4), 7'(50 + plots / 4), 3'd2}) perr++;
                plots++;
            end
            if (done === 3'b100) dones++;
            else if (done !== 3'b000) perr++;
            if (c == 2) begin
                req   = 3'b000;
                tx[2] = 8'd99; ty[2] = 7'd1; tc[2] = 3'd6;
            end
            @(negedge clk);
        end
        total++;
        if (plots !== 16) begin
            bad++;
            $display("FAIL drop_plots: got %0d want 16", plots);
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL drop_dones: got %0d want 1", dones);
        end
        total++;
        if (perr !== 0) begin
            bad++;
            $display("FAIL drop_pixels: got %0d wrong want 0", perr);
        end
    endtask

    initial begin
        resetn = 1'b1;
        req    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tx[i] = '0;
            ty[i] = '0;
            tc[i] = '0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_rr();
        test_wrap();
        test_reset_mid();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA pixel-plot path between several draw requesters: column pointer, player disc, board/cell clear.
- Each request is one TILE x TILE square at a base (x, y) in one colour.
- Grants one requester at a time and sequences the square's pixels, one per clock, onto the VGA adapter interface.
- Pulses a per-requester done when the square finishes.
- Sits between the game FSM/datapath and the VGA adapter.

Parameters:
- NREQ, 3, number of requesters; index 0 = highest fixed priority.
- TILE, 4, square side in pixels; power of two; TILE*TILE pixels per request.
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- CW, 3, colour width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-high reset (asserted = 1 resets, despite the name).
- req  in  NREQ  per-requester draw request; level; must be held until the matching done.
- req_x  in  NREQ*XW  packed base x; requester i at bits [i*XW +: XW].
- req_y  in  NREQ*YW  packed base y; same packing.
- req_colour  in  NREQ*CW  packed colour; same packing.
- grant  out  NREQ  one-hot; high for the owner from the DRAW entry edge through the last DRAW cycle.
- done  out  NREQ  one-hot, one-cycle pulse on completion.
- x_out  out  XW  pixel x to the VGA adapter.
- y_out  out  YW  pixel y to the VGA adapter.
- colour_out  out  CW  pixel colour to the VGA adapter.
- plot  out  1  adapter write enable; exactly one pixel per cycle while high.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (clk edge with resetn=1):
  - state = IDLE; pixel counter = 0; latched base, colour and owner = 0.
  - grant, done, plot, busy, x_out, y_out, colour_out = 0.
  - ROUND_ROBIN_EN pointer = NREQ-1.
- States: IDLE, DRAW, FINISH.
- IDLE:
  - If any req bit is 1, select the winner per the arbitration rule.
  - At that edge, latch the winner's x/y/colour and owner index; counter = 0; grant = onehot(winner); state -> DRAW.
  - If req = 0, stay in IDLE with all outputs 0.
- DRAW:
  - plot = 1.
  - col = counter[log2(TILE)-1:0]; row = counter[2*log2(TILE)-1:log2(TILE)].
  - x_out = base_x + col; y_out = base_y + row; colour_out = latched colour.
  - Raster order: row-major, x fastest.
  - Counter increments each cycle. On the cycle counter == TILE*TILE-1, the next state is FINISH.
- FINISH (one cycle):
  - plot = 0; grant = 0; done[owner] = 1; next state IDLE.
- Timing and latency:
  - Request sampled at edge E: plot is high for cycles E+1 .. E+TILE*TILE; done is high in cycle E+TILE*TILE+1.
  - Earliest next grant is at the edge ending the first IDLE cycle.
  - Minimum back-to-back period is TILE*TILE+2 cycles.
- All outputs come from registers or from latched state only; there is no combinational path from req/req_* to any output.
- Arithmetic: coordinate sums are truncated to XW/YW bits, so they wrap modulo 2^XW / 2^YW; no saturation, no error flag.
- Boundary conditions:
  - req of the owner dropped mid-DRAW: ignored; the square completes and done still pulses.
  - req_* changes mid-DRAW: ignored; values are latched.
  - Requester must deassert req in the done cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
  - Requests from non-owners during DRAW/FINISH are not dropped; they are re-arbitrated in IDLE.
  - Reset mid-DRAW or FINISH: immediate return to reset values; no done pulse; the square is partially drawn.
  - Simultaneous requests: exactly one winner per arbitration rule; losers wait with no timeout.

Optional Feature:
- Macro: VGA_DRAW_ARBITER_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search begins at index (pointer+1) mod NREQ and takes the first asserted req.
  - pointer <= winner at each grant edge.
  - After reset, index 0 wins first.
- Undefined: fixed priority, lowest asserted index wins; the pointer register is not instantiated.

Test Plan:
- Single request: req=3'b010, req_x[1]=10, req_y[1]=20, colour 3'd5 -> grant=010 next edge; 16 plot cycles with (x,y) = (10,20),(11,20),(12,20),(13,20),(10,21)...(13,23); colour_out=5 throughout; done=010 for one cycle; busy low afterwards.
- Simultaneous: req=3'b111, each held until its done -> fixed mode grant order 0,1,2; each done followed by one IDLE cycle; never two grant bits high.
- Round-robin (macro defined): req=3'b011 held continuously, re-raised after each done -> grants alternate 0,1,0,1; fixed mode under the same stimulus -> 0,0,0.
- Wrap: base x=254, y=126 -> x_out sequence 254,255,0,1; y_out sequence 126,127,0,1; no other side effects.
- Reset mid-draw: resetn=1 on the 7th plot cycle -> next cycle plot=0, grant=0, busy=0, done never pulsed; a fresh req afterwards gives a full 16-pixel square starting at col 0, row 0.
- Early req drop: owner drops req after 3 plot cycles -> all 16 pixels still plotted; done pulses once.
